// File: rtl/data_memory.sv
// data_memory: line-oriented backing store for the data cache.
// Each request (line read or line write) is accepted in IDLE and completes
// with a one-cycle ack_o exactly LATENCY cycles after acceptance. Writes
// return the line's previous contents on data_o. The array is not reset.
module data_memory #(
  parameter int LATENCY = 10,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  // The counter counts BUSY cycles. It reaches LATENCY-1 on the edge that
  // leaves BUSY, so it needs enough bits to hold LATENCY-1.
  localparam int CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 2);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               write_q;
  logic [255:0]       wdata_q;
  logic               accept;
  logic               commit;
  logic [255:0]       mem [DEPTH];

  // Byte-offset bits and bits above the line index do not select anything;
  // the name keeps them out of unused-signal reports.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  // State register: reset always returns to IDLE, aborting any request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept in IDLE, wait out the latency in BUSY, then spend
  // exactly one cycle in ACK, during which enable_i is not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs and per-cycle strobes derived from the current state.
  // commit marks the edge that enters ACK: array write and data_o load.
  always_comb begin
    accept = 1'b0;
    commit = 1'b0;
    ack_o  = 1'b0;
    case (state_q)
      IDLE: begin
        accept = enable_i;
      end
      BUSY: begin
        commit = (cnt_q == LAST_CNT);
      end
      ACK: begin
        ack_o = 1'b1;
      end
      default: begin
        ack_o = 1'b0;
      end
    endcase
  end

  // Latency counter: cleared on acceptance, advanced every BUSY cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Request capture: the in-flight request works only from these copies,
  // so later input changes cannot disturb it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      idx_q   <= addr_i[IDX_W+4:5];
      write_q <= write_i;
      wdata_q <= data_i;
    end
  end

  // Array write on the commit edge; a reset on that same edge wins.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Read port: load the line on the commit edge (old contents on a write)
  // and hold it until the next commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= '0;
    end else if (commit) begin
      data_o <= mem[idx_q];
    end
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The module SHALL have parameter LATENCY, default 10, meaning the number of cycles from request acceptance to ack_o; legal range 2..255.
REQ-002 The module SHALL have parameter IDX_W, default 9, meaning the line-index width; depth is 2^IDX_W lines of 256 bits.
REQ-003 The module SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst_i, input, 1, a synchronous active-high reset.
REQ-005 The module SHALL have port enable_i, input, 1, a request valid from the data cache.
REQ-006 The module SHALL have port write_i, input, 1: 1 = line write, 0 = line read; sampled with enable_i.
REQ-007 The module SHALL have port addr_i, input, 32, a byte address; bits [4:0] and bits above [IDX_W+4] SHALL be ignored.
REQ-008 The module SHALL have port data_i, input, 256, the write line data, sampled with enable_i.
REQ-009 The module SHALL have port ack_o, output, 1, a one-cycle completion pulse.
REQ-010 The module SHALL have port data_o, output, 256, the read line data, valid in the ack_o cycle.

Function
REQ-011 The state machine SHALL have states IDLE, BUSY and ACK.
REQ-012 In IDLE with enable_i=1, the module SHALL capture index=addr_i[IDX_W+4:5], data_i and write_i into registers, clear the cycle counter, and go to BUSY.
REQ-013 In IDLE with enable_i=0, the module SHALL remain in IDLE with no side effects.
REQ-014 In BUSY, the counter SHALL increment each cycle; enable_i, write_i, addr_i and data_i SHALL be ignored.
REQ-015 For a request accepted in cycle T, ack_o SHALL be 1 in cycle T+LATENCY exactly, and 0 in all other cycles.
REQ-016 The module SHALL enter ACK on the edge that raises ack_o, and SHALL leave ACK for IDLE unconditionally after one cycle.
REQ-017 enable_i seen during ACK SHALL NOT start a request; the next request SHALL be sampled in the cycle after ack_o, so a write-back immediately followed by a read with enable_i held high is accepted at T_ack+1.
REQ-018 On a write, the captured data SHALL be stored at the captured index on the edge that raises ack_o.
REQ-019 On a read, data_o SHALL be loaded on the edge that raises ack_o with the line at the captured index.
REQ-020 On a write, data_o SHALL be loaded with the line's pre-write contents.
REQ-021 data_o SHALL hold its value until the next ack_o edge.
REQ-022 Changes on the inputs after acceptance SHALL NOT affect the in-flight request.
REQ-023 Addresses differing only in ignored bits SHALL alias to the same line.
REQ-024 The counter SHALL be wide enough for LATENCY-1 and SHALL never wrap during a request.

Reset
REQ-025 While rst_i=1 at a clock edge, the state SHALL become IDLE, the counter 0, ack_o 0 and data_o 256'b0.
REQ-026 A reset during BUSY SHALL abort the request; a pending write SHALL NOT be committed unless its commit edge precedes the reset edge.
REQ-027 Memory array contents SHALL NOT be cleared by reset; the bench preloads the array hierarchically.
REQ-028 enable_i asserted in the same cycle as rst_i SHALL be ignored.

Verification
REQ-029 Read latency: with the line at index 3 preloaded to 256'hA5..A5 and LATENCY=10, a read of addr 0x60 at cycle 0 -> ack_o=1 only in cycle 10 and data_o=256'hA5..A5.
REQ-030 Write then read: write 0x0000_0400 with data {8{32'hDEADBEEF}} -> ack at +10; then read 0x0000_0400 -> data_o={8{32'hDEADBEEF}}.
REQ-031 Write-back then read miss: enable_i held at 1, write_i dropped the cycle after ack -> the second request is accepted at ack+1 with a second ack exactly 10 cycles later, and no third request is started.
REQ-032 Input perturbation: toggle addr_i and data_i during BUSY -> the captured values are used, and the other lines are unchanged.
REQ-033 Reset mid-write: rst_i high at cycle 5 of a write to index 7 -> ack_o is never raised, line 7 is unchanged, data_o=0, and a new request is accepted the cycle after rst_i falls.
REQ-034 Aliasing: write 0x0000_0020, then read 0x0000_4020 (IDX_W=9) -> returns the same line.
